// File: rtl/sprite_attr_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_attr_reader_if
// Description : Attribute RAM read port and hit-record stream of the
//               sprite attribute reader. master = reader, slave = RAM/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_attr_reader_if;
   logic        rd_en_o;
   logic [7:0]  rd_addr_o;
   logic [31:0] rd_data_i;
   logic        spr_valid_o;
   logic        spr_ready_i;
   logic [6:0]  spr_idx_o;
   logic [9:0]  spr_x_o;
   logic [5:0]  spr_row_o;
   logic [15:0] spr_addr_o;

   modport master (
      output rd_en_o, rd_addr_o, spr_valid_o, spr_idx_o, spr_x_o, spr_row_o, spr_addr_o,
      input  rd_data_i, spr_ready_i
   );

   modport slave (
      input  rd_en_o, rd_addr_o, spr_valid_o, spr_idx_o, spr_x_o, spr_row_o, spr_addr_o,
      output rd_data_i, spr_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/sprite_attr_reader.sv
`default_nettype none
// ============================================================================
// Module      : sprite_attr_reader
// Description : Per-scanline sprite attribute scanner. Walks the attribute
//               RAM (two words per sprite), tests vertical intersection with
//               the requested line and streams hits over valid/ready.
//               Optional macro SPRITE_ATTR_READER_DROP_CNT_EN adds drop_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_attr_reader #(
   parameter int NUM_SPRITES = 64,
   parameter int MAX_HITS    = 16
) (
   input  wire logic       clk_i,
   input  wire logic       rst_ni,
   input  wire logic       start_i,
   input  wire logic [9:0] line_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            overflow_o,
`ifdef SPRITE_ATTR_READER_DROP_CNT_EN
   output logic [6:0]      drop_cnt_o,
`endif
   sprite_attr_reader_if.master bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD0  = 3'd1;
   localparam logic [2:0] S_RD1  = 3'd2;
   localparam logic [2:0] S_EVAL = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [6:0] C_LAST_IDX = 7'(NUM_SPRITES - 1);
   localparam logic [7:0] C_MAX_HITS = 8'(MAX_HITS);

   logic [2:0]  state_q, state_d;
   logic [9:0]  line_q, line_d;
   logic [6:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [9:0]  x0_q, x0_d;
   logic [9:0]  y0_q, y0_d;
   logic [7:0]  rd_addr_q, rd_addr_d;
   logic [6:0]  rec_idx_q, rec_idx_d;
   logic [9:0]  rec_x_q, rec_x_d;
   logic [5:0]  rec_row_q, rec_row_d;
   logic [15:0] rec_addr_q, rec_addr_d;
   logic [6:0]  drop_q, drop_d;

   logic [9:0]  w_row;
   logic [6:0]  w_height;
   logic        w_hit;
   logic        w_full;
   logic        w_last;
   logic        w_unused;

   // Vertical intersection: word0 is registered, word1 arrives on the bus in EVAL.
   // 10-bit subtraction wraps, so sprites crossing line 1023->0 still intersect.
   assign w_row    = line_q - y0_q;
   assign w_height = (bus.rd_data_i[21:16] == 6'd0) ? 7'd64 : {1'b0, bus.rd_data_i[21:16]};
   assign w_hit    = bus.rd_data_i[31] && (w_row < {3'b000, w_height});
   assign w_full   = (cnt_q >= C_MAX_HITS);
   assign w_last   = (idx_q == C_LAST_IDX);
   assign w_unused = ^{bus.rd_data_i[30:22], drop_q};

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) state_d = S_RD0;
         S_RD0:  state_d = S_RD1;
         S_RD1:  state_d = S_EVAL;
         S_EVAL: begin
            if (w_hit && !w_full) state_d = S_OUT;
            else                  state_d = w_last ? S_DONE : S_RD0;
         end
         S_OUT:  if (bus.spr_ready_i) state_d = w_last ? S_DONE : S_RD0;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; record fields come straight from their holding registers
   always_comb begin
      busy_o          = (state_q != S_IDLE);
      done_o          = (state_q == S_DONE);
      overflow_o      = ovf_q;
      bus.rd_en_o     = (state_q == S_RD0) || (state_q == S_RD1);
      bus.rd_addr_o   = rd_addr_d;
      bus.spr_valid_o = (state_q == S_OUT);
      bus.spr_idx_o   = rec_idx_q;
      bus.spr_x_o     = rec_x_q;
      bus.spr_row_o   = rec_row_q;
      bus.spr_addr_o  = rec_addr_q;
   end

`ifdef SPRITE_ATTR_READER_DROP_CNT_EN
   assign drop_cnt_o = drop_q;
`endif

   // Datapath next values: scan index, hit count, word0 capture, record load
   always_comb begin
      line_d     = line_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      rd_addr_d  = rd_addr_q;
      rec_idx_d  = rec_idx_q;
      rec_x_d    = rec_x_q;
      rec_row_d  = rec_row_q;
      rec_addr_d = rec_addr_q;
      drop_d     = drop_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               line_d = line_i;
               idx_d  = 7'd0;
               cnt_d  = 8'd0;
               ovf_d  = 1'b0;
               drop_d = 7'd0;
            end
         end
         S_RD0: rd_addr_d = {idx_q, 1'b0};
         S_RD1: begin
            rd_addr_d = {idx_q, 1'b1};
            x0_d      = bus.rd_data_i[9:0];
            y0_d      = bus.rd_data_i[25:16];
         end
         S_EVAL: begin
            if (w_hit && !w_full) begin
               rec_idx_d  = idx_q;
               rec_x_d    = x0_q;
               rec_row_d  = w_row[5:0];
               rec_addr_d = bus.rd_data_i[15:0];
            end else begin
               if (w_hit) begin
                  ovf_d = 1'b1;
                  if (drop_q != 7'd127) drop_d = drop_q + 7'd1;
               end
               if (!w_last) idx_d = idx_q + 7'd1;
            end
         end
         S_OUT: begin
            if (bus.spr_ready_i) begin
               cnt_d = cnt_q + 8'd1;
               if (!w_last) idx_d = idx_q + 7'd1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         x0_q       <= '0;
         y0_q       <= '0;
         rd_addr_q  <= '0;
         rec_idx_q  <= '0;
         rec_x_q    <= '0;
         rec_row_q  <= '0;
         rec_addr_q <= '0;
         drop_q     <= '0;
      end else begin
         line_q     <= line_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         rd_addr_q  <= rd_addr_d;
         rec_idx_q  <= rec_idx_d;
         rec_x_q    <= rec_x_d;
         rec_row_q  <= rec_row_d;
         rec_addr_q <= rec_addr_d;
         drop_q     <= drop_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/sprite_attr_reader.md
# sprite_attr_reader

Scanline sprite attribute reader on the read port of the sprite attribute RAM (256 x 32, one-cycle synchronous read). On a per-line start pulse it walks the sprite table in index order, fetches two words per sprite, tests vertical intersection with the requested line and streams hits to the sprite line renderer over a valid/ready handshake. Hits beyond the per-line limit are dropped and flagged.

## Interface
- NUM_SPRITES, 64: sprites scanned per line (1..128); sprite n occupies words 2n, 2n+1.
- MAX_HITS, 16: maximum hits emitted per line (1..NUM_SPRITES).
- clk_i  in  1  single clock for the block and the RAM read port.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse: begin scan of line_i; ignored unless idle.
- line_i  in  10  line number, sampled on accepted start_i.
- busy_o  out  1  high from accepted start_i until done_o.
- done_o  out  1  one-cycle pulse after last sprite processed.
- overflow_o  out  1  set during a line when a hit is dropped; cleared on next accepted start_i.
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  8  RAM read address.
- rd_data_i  in  32  RAM read data, valid the cycle after rd_en_o.
- spr_valid_o  out  1  hit record valid.
- spr_ready_i  in  1  consumer accepts record when valid and ready.
- spr_idx_o  out  7  sprite index.
- spr_x_o  out  10  sprite X.
- spr_row_o  out  6  row within sprite (line - Y).
- spr_addr_o  out  16  pixel data base address.

## Operation
- Word0: X = [9:0], Y = [25:16]. Word1: addr = [15:0], height = [21:16] (0 encodes 64), enable = [31].
- Hit: enable=1 and row = (line - Y) mod 1024 < height; 10-bit wrap arithmetic, so sprites spanning line 1023->0 hit correctly; row is the low 6 bits.
- FSM states: IDLE, RD0, RD1, EVAL, OUT, DONE.
- IDLE: on start_i latch line, clear idx, hit count, overflow_o; go RD0.
- RD0: rd_en_o=1, rd_addr_o=2*idx; go RD1.
- RD1: rd_en_o=1, rd_addr_o=2*idx+1; capture word0; go EVAL.
- EVAL: capture word1, evaluate hit. Hit and count<MAX_HITS: load record, go OUT. Hit and count=MAX_HITS: set overflow_o, advance. Miss: advance.
- OUT: spr_valid_o=1, record stable; on spr_ready_i increment count, advance.
- Advance: idx=NUM_SPRITES-1 -> DONE, else idx+1 -> RD0.
- DONE: done_o=1 one cycle; go IDLE.
- rd_en_o=0 in all other states; rd_addr_o holds last value.
- start_i while busy_o=1 is ignored; line latch unchanged.

## Timing
- Reset values: busy_o=0, done_o=0, overflow_o=0, rd_en_o=0, rd_addr_o=0, spr_valid_o=0, spr_idx_o/x/row/addr=0, state IDLE.
- Miss or dropped hit: 3 cycles per sprite (RD0, RD1, EVAL).
- Hit with ready held high: 4 cycles per sprite; spr_valid_o asserts 3 cycles after RD0.
- Minimum line: start_i at cycle 0, busy_o at 1, done_o at 3*NUM_SPRITES+1 with no hits.
- spr_valid_o never deasserts without acceptance; backpressure stalls the scan, no RAM reads issued while in OUT.
- Reset mid-scan returns to IDLE immediately; outputs take reset values; no done_o.

## Configuration
- SPRITE_ATTR_READER_DROP_CNT_EN: defined adds output drop_cnt_o (7 bits), cleared on accepted start_i, incremented per dropped hit, saturating at 127, reset 0. Undefined: port absent, only overflow_o reports drops.

## Test plan
- Empty table (all words 0), start line 100 -> no spr_valid_o, done_o exactly 193 cycles after start (NUM_SPRITES=64), overflow_o=0.
- Sprite 5: X=40, Y=98, height=4, addr=0x1234, enable -> line 100 yields one record idx=5, x=40, row=2, addr=0x1234; line 102 yields none.
- Sprite 0 Y=1022 height=4 -> line 1 hits with row=3; line 2 misses (wrap check).
- 20 enabled sprites covering line 10, MAX_HITS=16 -> records idx 0..15 in order, overflow_o=1, drop_cnt_o=4 when macro defined.
- spr_ready_i low for 10 cycles on first hit -> record held stable, rd_en_o stays 0, scan resumes after acceptance, no lost records.
- rst_ni low during OUT -> all outputs zero asynchronously; next start_i performs a full, correct scan.
